// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of ALU and load writebacks into one RF write port,
// plus per-register pending counters that drive RAW-hazard stalls for the issue stage.
module rf_wb_scheduler #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int CW = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_reg,
  input  logic [DW-1:0]    alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_reg,
  input  logic [DW-1:0]    mem_data,
  output logic             mem_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wreg,
  output logic [DW-1:0]    rf_wdata,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_reg,
  input  logic             rd1_en,
  input  logic             rd2_en,
  input  logic [AW-1:0]    rd1_reg,
  input  logic [AW-1:0]    rd2_reg,
  output logic [2**AW-1:0] busy,
  output logic             stall,
  output logic [1:0]       err
);

  localparam int NR = 2**AW;

  typedef enum logic {GR_ALU = 1'b0, GR_MEM = 1'b1} grant_t;

  grant_t        last_grant;
  logic [CW-1:0] cnt     [NR];
  logic [CW-1:0] cnt_nxt [NR];
  logic          xfer;
  logic [AW-1:0] win_reg;
  logic [DW-1:0] win_data;
  logic          inc, dec, ovf, unf;

  // Readies are gated by rstn so nothing is accepted while reset is held.
  always_comb begin
    alu_ready = rstn && alu_valid && (!mem_valid || last_grant == GR_MEM);
    mem_ready = rstn && mem_valid && (!alu_valid || last_grant == GR_ALU);
    xfer      = alu_ready || mem_ready;
    win_reg   = alu_ready ? alu_reg  : mem_reg;
    win_data  = alu_ready ? alu_data : mem_data;
  end

  // A reservation and a commit to the same register cancel out, with no limit checks.
  always_comb begin
    ovf = 1'b0;
    unf = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 0; r < NR; r++) begin
      inc        = rsv_valid && (rsv_reg == AW'(r));
      dec        = xfer && (win_reg == AW'(r));
      cnt_nxt[r] = cnt[r];
      if (inc && !dec) begin
        if (cnt[r] == '1) ovf = 1'b1;
        else              cnt_nxt[r] = cnt[r] + CW'(1);
      end else if (dec && !inc) begin
        if (cnt[r] == '0) unf = 1'b1;
        else              cnt_nxt[r] = cnt[r] - CW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NR; r++) busy[r] = (cnt[r] != '0);
    stall = (rd1_en && busy[rd1_reg]) || (rd2_en && busy[rd2_reg]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= GR_MEM;
      rf_we      <= 1'b0;
      rf_wreg    <= '0;
      rf_wdata   <= '0;
      err        <= '0;
      for (int unsigned r = 0; r < NR; r++) cnt[r] <= '0;
    end else begin
      rf_we <= xfer;
      if (xfer) begin
        rf_wreg    <= win_reg;
        rf_wdata   <= win_data;
        last_grant <= alu_ready ? GR_ALU : GR_MEM;
      end
      for (int unsigned r = 0; r < NR; r++) cnt[r] <= cnt_nxt[r];
      err <= err | {unf, ovf};
    end
  end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- DW, 16, write data width
- AW, 3, register index width; 2**AW registers
- CW, 2, per-register pending-count width
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU writeback request
- alu_reg  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load-unit writeback request
- mem_reg  in  AW  load destination register
- mem_data  in  DW  load result
- mem_ready  out  1  load request accepted this cycle
- rf_we  out  1  register-file write enable
- rf_wreg  out  AW  register-file write index
- rf_wdata  out  DW  register-file write data
- rsv_valid  in  1  issue stage reserves a destination
- rsv_reg  in  AW  reserved register
- rd1_en, rd2_en  in  1 each  issue source operand in use
- rd1_reg, rd2_reg  in  AW each  issue source indices
- busy  out  2**AW  per-register write-pending flags
- stall  out  1  issue must hold, RAW hazard
- err  out  2  sticky errors: [0] count overflow, [1] commit with no reservation

Function
REQ-003 SHALL define a transfer as valid && ready in the same cycle.
REQ-004 SHALL assert at most one of alu_ready/mem_ready per cycle; ready SHALL be combinational from the valids and the round-robin pointer.
- If only one requester is valid, that requester SHALL get ready.
- If neither is valid, both readies SHALL be 0.
REQ-005 SHALL arbitrate with a 1-bit round-robin pointer last_grant.
- When both are valid, the requester not equal to last_grant SHALL win.
- last_grant SHALL update to the winner on every transfer and hold otherwise.
REQ-006 SHALL register the winner into rf_we/rf_wreg/rf_wdata on the same rising edge as the transfer, giving one-cycle latency to the RF write.
- rf_we SHALL be 0 in any cycle following a cycle with no transfer.
REQ-007 SHALL sustain one RF write per cycle with no bubbles while requests are present.
REQ-008 SHALL keep a CW-bit pending count cnt[r] per register; busy[r] = (cnt[r] != 0).
REQ-009 SHALL increment cnt[rsv_reg] on each edge where rsv_valid is 1.
REQ-010 SHALL decrement cnt[r] on each edge where a transfer targets r (commit).
REQ-011 SHALL leave cnt[r] unchanged when a reservation and a commit hit the same r on the same edge.
REQ-012 SHALL handle count limits:
- Reservation at cnt = 2**CW-1: count SHALL saturate (unchanged) and err[0] SHALL set.
- Commit at cnt = 0: count SHALL stay 0, err[1] SHALL set, and the RF write SHALL still be performed.
REQ-013 SHALL drive stall combinationally = (rd1_en && busy[rd1_reg]) || (rd2_en && busy[rd2_reg]), using the registered busy value with no same-cycle bypass.
REQ-014 SHALL keep err bits sticky until reset.
REQ-015 SHALL treat both requesters targeting the same register in one cycle as two ordinary transfers, serialized by REQ-005 and committing in grant order.

Reset
REQ-016 SHALL, while rstn = 0, asynchronously clear rf_we, rf_wreg, rf_wdata, every cnt, busy, err, and set last_grant = MEM so ALU wins the first contention.
REQ-017 SHALL hold alu_ready = mem_ready = 0 while rstn = 0.
REQ-018 SHALL discard any in-flight write on reset mid-operation; the first edge after deassertion SHALL behave as a fresh start.

Verification
REQ-019 SHALL cover these directed scenarios:
- Reset, then alu_valid=1, alu_reg=5, alu_data=16'hBEEF for one cycle -> alu_ready=1; next cycle rf_we=1, rf_wreg=5, rf_wdata=16'hBEEF; the following cycle rf_we=0.
- Both valid for 4 consecutive cycles -> grants ALU, MEM, ALU, MEM; rf_we=1 on 4 consecutive cycles.
- rsv_valid on reg 3; next cycle rd1_en=1, rd1_reg=3 -> stall=1; commit to reg 3 -> busy[3]=0 and stall=0 on the following cycle.
- rsv reg 2 twice, then one commit -> busy[2] stays 1; second commit -> busy[2]=0; simultaneous rsv+commit on reg 2 at cnt=1 -> cnt stays 1.
- Four reservations of reg 7 with no commit -> cnt=3 and err[0]=1; an ALU commit to reg 0 with cnt=0 -> err[1]=1 and the RF write still occurs.
- rstn pulsed low mid-burst with cnt[4]=2 -> all outputs 0 immediately; after release busy=0, err=0, and ALU wins the first contention.
